code_conv_seq: RTL and testbench

Sequential conversion engine that sits directly upstream of the result-load register stage.
- Accepts a binary operand and a mode on a start handshake.
- Computes Gray, BCD (iterative double-dabble, one bit per cycle) and Excess-3.
- Drives sel/ldR so the downstream stage captures the selected result, then signals done.

---
 rtl/code_conv_seq_pkg.sv | 27 ++
 rtl/code_conv_seq_if.sv | 26 ++
 rtl/code_conv_seq_dd_step.sv | 18 +
 rtl/code_conv_seq.sv | 138 +++++++++++++
 tb/tb_code_conv_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/code_conv_seq_pkg.sv
// Shared types and constants for the code conversion engine.
package code_conv_pkg;

    localparam logic [1:0] MODE_ILL  = 2'b00;
    localparam logic [1:0] MODE_GRAY = 2'b01;
    localparam logic [1:0] MODE_BCD  = 2'b10;
    localparam logic [1:0] MODE_XS3  = 2'b11;

    localparam logic [3:0] XS3_BIAS = 4'd3;

    // Wide enough to count IN_W iterations for IN_W up to 6.
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        XS3,
        LOAD,
        DONE
    } state_t;

    // Bias each BCD digit independently; no carry between digits.
    function automatic logic [7:0] xs3_of(input logic [7:0] bcd);
        return {bcd[7:4] + XS3_BIAS, bcd[3:0] + XS3_BIAS};
    endfunction

endpackage

// File: rtl/code_conv_seq_if.sv
// Request/result bundle between the requester and the conversion engine.
interface code_conv_seq_if #(
    parameter int IN_W = 4
);
    logic            start;
    logic [1:0]      mode;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic            err;
    logic [1:0]      sel;
    logic            ldR;
    logic [IN_W-1:0] gray_result;
    logic [7:0]      bcd_result;
    logic [7:0]      Excess3_result;

    modport master (
        output start, mode, bin_in,
        input  busy, done, err, sel, ldR, gray_result, bcd_result, Excess3_result
    );

    modport slave (
        input  start, mode, bin_in,
        output busy, done, err, sel, ldR, gray_result, bcd_result, Excess3_result
    );
endinterface

// File: rtl/code_conv_seq_dd_step.sv
// One double-dabble iteration: adjust digits >= 5, then shift in the next operand bit.
module dd_step
    import code_conv_pkg::*;
(
    input  logic [7:0] acc_i,
    input  logic       bit_i,
    output logic [7:0] acc_o
);
    logic [7:0] adj;

    // Add 3 to each digit that would overflow past 9 after doubling.
    always_comb begin
        adj = acc_i;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        acc_o = 8'({adj, bit_i});
    end
endmodule

// File: rtl/code_conv_seq.sv
// Sequential Gray / BCD / Excess-3 converter feeding the result-load stage.
module code_conv_seq
    import code_conv_pkg::*;
#(
    parameter int IN_W = 4
) (
    input logic           clk,
    input logic           rst,
    code_conv_seq_if.slave bus
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic [IN_W-1:0]   sh_q, sh_d;
    logic [IN_W-1:0]   bin_q, bin_d;
    logic [1:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ldr_q, ldr_d;
    logic [1:0]        sel_q, sel_d;
    logic [IN_W-1:0]   gray_q, gray_d;
    logic [7:0]        bcd_q, bcd_d;
    logic [7:0]        xs3_q, xs3_d;
    logic [7:0]        dd_out;

    dd_step u_dd (
        .acc_i (acc_q),
        .bit_i (sh_q[IN_W-1]),
        .acc_o (dd_out)
    );

    // Next-state and output decode; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        bin_d   = bin_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ldr_d   = 1'b0;
        sel_d   = sel_q;
        gray_d  = gray_q;
        bcd_d   = bcd_q;
        xs3_d   = xs3_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mode == MODE_ILL) begin
                        err_d = 1'b1;
                    end else begin
                        bin_d   = bus.bin_in;
                        sh_d    = bus.bin_in;
                        mode_d  = bus.mode;
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                acc_d = dd_out;
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W - 1)) state_d = XS3;
            end
            XS3: begin
                bcd_d   = acc_q;
                xs3_d   = xs3_of(acc_q);
                gray_d  = bin_q ^ (bin_q >> 1);
                sel_d   = mode_q;
                state_d = LOAD;
            end
            LOAD: begin
                // Results and sel settle a cycle ahead, then the strobe fires for one cycle.
                if (!ldr_q) begin
                    ldr_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            bin_q   <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ldr_q   <= 1'b0;
            sel_q   <= '0;
            gray_q  <= '0;
            bcd_q   <= '0;
            xs3_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            bin_q   <= bin_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ldr_q   <= ldr_d;
            sel_q   <= sel_d;
            gray_q  <= gray_d;
            bcd_q   <= bcd_d;
            xs3_q   <= xs3_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.ldR            = ldr_q;
    assign bus.sel            = sel_q;
    assign bus.gray_result    = gray_q;
    assign bus.bcd_result     = bcd_q;
    assign bus.Excess3_result = xs3_q;
endmodule

// File: tb/tb_code_conv_seq.sv
// Self-checking bench: vector table, timing checks per conversion, scoreboard on done.
module tb_code_conv_seq;
    localparam int IN_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    code_conv_seq_if #(.IN_W(IN_W)) bus ();

    code_conv_seq #(.IN_W(IN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [IN_W-1:0] bin;
        logic [1:0]      mode;
        logic [7:0]      bcd;
        logic [IN_W-1:0] gray;
        logic [7:0]      xs3;
    } vec_t;

    typedef struct {
        logic [7:0]      bcd;
        logic [IN_W-1:0] gray;
        logic [7:0]      xs3;
        logic [1:0]      sel;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   ldr_cnt   = 0;
    int   done_cnt  = 0;
    int   exp_done  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input vec_t v);
        sb.push_back(exp_t'{v.bcd, v.gray, v.xs3, v.mode});
        exp_done++;
    endtask

    task automatic chk_results(input string tag, input vec_t v);
        chk({tag, "_bcd"},  bus.bcd_result,     v.bcd);
        chk({tag, "_gray"}, bus.gray_result,    v.gray);
        chk({tag, "_xs3"},  bus.Excess3_result, v.xs3);
        chk({tag, "_sel"},  bus.sel,            v.mode);
    endtask

    // One conversion with per-edge timing checks; disturb drives a competing start mid-CONV.
    task automatic run_conv(input vec_t v, input bit disturb);
        bus.start  = 1'b1;
        bus.bin_in = v.bin;
        bus.mode   = v.mode;
        tick();
        push_exp(v);
        bus.start = 1'b0;
        chk("busy_accept", bus.busy, 1);
        for (int k = 1; k <= IN_W + 5; k++) begin
            if (disturb && k == 2) begin
                bus.start  = 1'b1;
                bus.bin_in = 4'd3;
                bus.mode   = 2'b01;
            end
            if (disturb && k == 4) bus.start = 1'b0;
            tick();
            chk("ldR_timing",  bus.ldR,  k == IN_W + 2);
            chk("done_timing", bus.done, k == IN_W + 3);
            chk("busy_timing", bus.busy, k <= IN_W + 3);
            chk("err_quiet",   bus.err,  0);
            if (k == IN_W + 2) chk("sel_at_ldR", bus.sel, v.mode);
        end
        chk_results("hold", v);
    endtask

    // Scoreboard and protocol invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ldR_done_excl", bus.ldR & bus.done, 0);
            chk("err_busy_excl", bus.err & bus.busy, 0);
            if (bus.ldR) begin
                ldr_cnt++;
                if (sb.size() > 0) chk("sel_during_ldR", bus.sel, sb[0].sel);
            end
            if (bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow actual=done expected=no_done @%0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_bcd",  bus.bcd_result,     e.bcd);
                    chk("sb_gray", bus.gray_result,    e.gray);
                    chk("sb_xs3",  bus.Excess3_result, e.xs3);
                    chk("sb_sel",  bus.sel,            e.sel);
                end
            end
        end
    end

    initial begin
        vec_t vecs[5];
        vec_t v9, v5;
        int   sv_ldr, sv_done;

        vecs[0] = '{4'd9,  2'b10, 8'h09, 4'b1101, 8'h3C};
        vecs[1] = '{4'd15, 2'b11, 8'h15, 4'b1000, 8'h48};
        vecs[2] = '{4'd0,  2'b01, 8'h00, 4'b0000, 8'h33};
        vecs[3] = '{4'd10, 2'b10, 8'h10, 4'b1111, 8'h43};
        vecs[4] = '{4'd12, 2'b01, 8'h12, 4'b1010, 8'h45};
        v9      = '{4'd9,  2'b10, 8'h09, 4'b1101, 8'h3C};
        v5      = '{4'd5,  2'b10, 8'h05, 4'b0111, 8'h38};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mode   = 2'b00;
        bus.bin_in = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err",  bus.err,  0);
        chk("rst_ldR",  bus.ldR,  0);
        chk("rst_sel",  bus.sel,  0);
        chk("rst_gray", bus.gray_result,    0);
        chk("rst_bcd",  bus.bcd_result,     0);
        chk("rst_xs3",  bus.Excess3_result, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_conv(vecs[i], 1'b0);

        // Competing start with a different operand while converting is ignored.
        run_conv(v9, 1'b1);

        // Illegal mode: err pulse only, nothing else moves.
        sv_ldr  = ldr_cnt;
        sv_done = done_cnt;
        bus.start  = 1'b1;
        bus.mode   = 2'b00;
        bus.bin_in = 4'd7;
        tick();
        bus.start = 1'b0;
        chk("ill_err",  bus.err,  1);
        chk("ill_busy", bus.busy, 0);
        tick();
        chk("ill_err_pulse", bus.err, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ill_busy_idle", bus.busy, 0);
        end
        chk("ill_ldr_cnt",  ldr_cnt,  sv_ldr);
        chk("ill_done_cnt", done_cnt, sv_done);
        chk_results("ill_hold", v9);

        // Reset in the middle of CONV aborts with no load or done.
        bus.start  = 1'b1;
        bus.mode   = 2'b11;
        bus.bin_in = 4'd9;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_ldR",  bus.ldR,  0);
        chk("mid_rst_sel",  bus.sel,  0);
        chk("mid_rst_gray", bus.gray_result,    0);
        chk("mid_rst_bcd",  bus.bcd_result,     0);
        chk("mid_rst_xs3",  bus.Excess3_result, 0);
        sv_ldr  = ldr_cnt;
        sv_done = done_cnt;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("abort_ldr_cnt",  ldr_cnt,  sv_ldr);
        chk("abort_done_cnt", done_cnt, sv_done);
        chk("abort_busy",     bus.busy, 0);

        // start held high: accepts every IN_W+5 edges.
        bus.start  = 1'b1;
        bus.bin_in = v5.bin;
        bus.mode   = v5.mode;
        sv_ldr  = ldr_cnt;
        tick();
        push_exp(v5);
        for (int k = 1; k <= 2 * (IN_W + 5) + IN_W + 4; k++) begin
            int ph;
            if (k == 2 * (IN_W + 5) + 2) bus.start = 1'b0;
            tick();
            ph = k % (IN_W + 5);
            if (ph == 0) push_exp(v5);
            chk("b2b_ldR",  bus.ldR,  ph == IN_W + 2);
            chk("b2b_done", bus.done, ph == IN_W + 3);
            chk("b2b_busy", bus.busy, ph != IN_W + 4);
        end
        tick();
        chk("b2b_ldr_cnt", ldr_cnt - sv_ldr, 3);
        chk_results("b2b_hold", v5);

        chk("final_done_cnt", done_cnt, exp_done);
        chk("final_ldr_cnt",  ldr_cnt,  exp_done);
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
